fp_add_arbiter: RTL and testbench

//   Shares one combinational fp_adder (IEEE-754 double add) between NREQ requesters.

---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_add_arbiter_rr_pick.sv | 34 +++
 rtl/fp_adder.sv | 91 +++++++++
 rtl/fp_add_arbiter.sv | 85 ++++++++
 tb/tb_fp_add_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants for the adder arbiter slice.
// Field widths of IEEE-754 double plus a few handy operand values.
package fp_pkg;

    localparam int FP_W       = 64;
    localparam int FP_EXP_W   = 11;
    localparam int FP_MAN_W   = 52;
    localparam int FP_SGN_BIT = 63;

    localparam logic [FP_W-1:0] FP_ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [FP_W-1:0] FP_TWO   = 64'h4000_0000_0000_0000;
    localparam logic [FP_W-1:0] FP_THREE = 64'h4008_0000_0000_0000;
    localparam logic [FP_W-1:0] FP_QNAN  = 64'h7FF8_0000_0000_0000;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 11'h7FF;

endpackage

// File: rtl/fp_add_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, with wrap.
// Ports: req, ptr in; gnt one-hot, idx, any out.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW:0] cand;

    // scan from the far end so the last hit is the nearest to ptr
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (req[cand[IDW-1:0]]) begin
                any = 1'b1;
                idx = cand[IDW-1:0];
            end
        end
        gnt[idx] = any;
    end

endmodule

// File: rtl/fp_adder.sv
// Combinational IEEE-754 double adder, round-to-nearest-even.
// Ports: a, b operands; sum = a + b.
module fp_adder
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] sum
);

    function automatic logic [5:0] lzc56(input logic [55:0] v);
        lzc56 = 6'd56;
        for (int i = 0; i < 56; i++)
            if (v[i]) lzc56 = 6'(55 - i);
    endfunction

    logic [63:0]  x, y;
    logic [10:0]  ex, ey;
    logic [11:0]  ex_eff, ey_eff, d, e_norm, ef;
    logic [52:0]  mx, my;
    logic [5:0]   sft, lz, sh;
    logic [119:0] wide;
    logic [55:0]  al, n;
    logic [56:0]  s;
    logic [53:0]  m54;
    logic         eff_sub, rup;
    logic         x_nan, y_nan, x_inf, y_inf;

    always_comb begin
        // x always carries the larger magnitude, so x - y never goes negative
        if (a[62:0] < b[62:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        ex = x[62:52];
        ey = y[62:52];
        mx = {ex != 11'd0, x[51:0]};
        my = {ey != 11'd0, y[51:0]};
        ex_eff = {1'b0, (ex == 11'd0) ? 11'd1 : ex};
        ey_eff = {1'b0, (ey == 11'd0) ? 11'd1 : ey};
        d = ex_eff - ey_eff;
        sft = (d > 12'd63) ? 6'd63 : d[5:0];
        // align y with 3 extra bits (guard, round, sticky)
        wide = {my, 67'd0} >> sft;
        al = wide[119:64];
        al[0] = al[0] | (|wide[63:0]);
        eff_sub = x[63] ^ y[63];
        if (eff_sub)
            s = {1'b0, mx, 3'b000} - {1'b0, al};
        else
            s = {1'b0, mx, 3'b000} + {1'b0, al};
        lz = lzc56(s[55:0]);
        // never normalise below exponent 1: that becomes a subnormal
        if ({6'd0, lz} > ex_eff - 12'd1)
            sh = 6'(ex_eff - 12'd1);
        else
            sh = lz;
        if (s[56]) begin
            n = {s[56:2], s[1] | s[0]};
            e_norm = ex_eff + 12'd1;
        end else begin
            n = s[55:0] << sh;
            e_norm = ex_eff - {6'd0, sh};
        end
        rup = n[2] & (n[1] | n[0] | n[3]);
        m54 = {1'b0, n[55:3]} + {53'd0, rup};
        if (m54[53])
            ef = e_norm + 12'd1;
        else if (m54[52])
            ef = e_norm;
        else
            ef = 12'd0;
        sum = {x[63], ef[10:0], m54[51:0]};
        if (ef >= {1'b0, FP_EXP_MAX})
            sum = {x[63], FP_EXP_MAX, 52'd0};
        if (s == 57'd0)
            sum = {eff_sub ? 1'b0 : x[63], 63'd0};
        x_nan = (ex == FP_EXP_MAX) && (x[51:0] != 52'd0);
        y_nan = (ey == FP_EXP_MAX) && (y[51:0] != 52'd0);
        x_inf = (ex == FP_EXP_MAX) && (x[51:0] == 52'd0);
        y_inf = (ey == FP_EXP_MAX) && (y[51:0] == 52'd0);
        if (x_nan || y_nan || (x_inf && y_inf && eff_sub))
            sum = FP_QNAN;
        else if (x_inf)
            sum = x;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fp_adder among NREQ requesters via round-robin grant.
// Ports: req_* operand handshake in, rsp_* result handshake out, busy.
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]      rsp_sum,
    output logic                 busy
);

    logic            s1_vld, s2_vld;
    logic [FP_W-1:0] s1_a, s1_b, s2_sum, add_sum;
    logic [IDW-1:0]  s1_id, s2_id, ptr, pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_any, s2_hold, s1_open, accept;
    logic [FP_W-1:0] sel_a, sel_b;
    logic            sel_sub;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    fp_adder u_add (
        .a   (s1_a),
        .b   (s1_b),
        .sum (add_sum)
    );

    assign s2_hold   = s2_vld & ~rsp_ready[s2_id];
    assign s1_open   = ~s1_vld | ~s2_hold;
    assign accept    = s1_open & pick_any & ~rst;
    assign req_ready = accept ? pick_gnt : '0;
    assign sel_a     = req_a[pick_idx*FP_W +: FP_W];
    assign sel_b     = req_b[pick_idx*FP_W +: FP_W];
    assign sel_sub   = req_sub[pick_idx];
    assign rsp_valid = s2_vld ? (NREQ'(1) << s2_id) : '0;
    assign rsp_sum   = s2_sum;
    assign busy      = s1_vld | s2_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            ptr    <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
            s2_sum <= '0;
            s2_id  <= '0;
        end else begin
            if (!s2_hold) begin
                s2_vld <= s1_vld;
                // keep the last result on the bus while idle
                if (s1_vld) begin
                    s2_sum <= add_sum;
                    s2_id  <= s1_id;
                end
            end
            if (s1_open)
                s1_vld <= accept;
            if (accept) begin
                s1_a  <= sel_a;
                s1_b  <= {sel_b[FP_SGN_BIT] ^ sel_sub, sel_b[FP_W-2:0]};
                s1_id <= pick_idx;
                ptr   <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: scenario tasks plus
// a queue-based reference model using real-number addition.
module tb_fp_add_arbiter;
    import fp_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_sub, req_ready, rsp_valid, rsp_ready;
    logic [N*64-1:0] req_a, req_b;
    logic [63:0]     rsp_sum;
    logic            busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [63:0] sum;
        int          t;
    } op_t;

    op_t         q[$];
    int          ptr_m = 0;
    int          cyc = 0;
    int          exp_g;
    logic [N-1:0] exp_rr, exp_rv;
    logic [63:0] exp_sum;
    logic        exp_busy;

    always #5 clk = ~clk;

    fp_add_arbiter #(.NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sub   (req_sub),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .busy      (busy)
    );

    function automatic logic [63:0] ref_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic sub);
        real r;
        r = $bitstoreal(a) + $bitstoreal({b[63] ^ sub, b[62:0]});
        return $realtobits(r);
    endfunction

    function automatic logic [63:0] rand_fp();
        logic [63:0] v;
        v[63]    = 1'($urandom_range(0, 1));
        v[62:52] = 11'($urandom_range(1000, 1040));
        v[51:32] = 20'($urandom);
        v[31:0]  = $urandom;
        return v;
    endfunction

    // Expected outputs for the current inputs and model state.
    task automatic expect_now();
        bit consume;
        int g;
        exp_rv  = '0;
        exp_sum = '0;
        consume = 0;
        if (q.size() > 0 && cyc >= q[0].t + 2) begin
            exp_rv  = N'(1) << q[0].id;
            exp_sum = q[0].sum;
            consume = rsp_ready[q[0].id];
        end
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        exp_g    = (!rst && (q.size() < 2 || consume)) ? g : -1;
        exp_rr   = (exp_g >= 0) ? N'(1) << exp_g : '0;
        exp_busy = q.size() > 0;
    endtask

    // Advance model and DUT by one clock; returns at the next negedge.
    task automatic tick();
        expect_now();
        if (rst) begin
            q.delete();
            ptr_m = 0;
        end else begin
            if (exp_rv != '0 && rsp_ready[q[0].id]) void'(q.pop_front());
            if (exp_g >= 0) begin
                q.push_back('{exp_g,
                              ref_add(req_a[64*exp_g +: 64], req_b[64*exp_g +: 64],
                                      req_sub[exp_g]),
                              cyc});
                ptr_m = (exp_g + 1) % N;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [63:0] a,
                          input logic [63:0] b, input logic sub);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_sub[i] = sub;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_sub = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = '1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
        end
        checks++;
        if (rsp_sum !== 64'd0) begin
            errors++;
            $display("FAIL reset_sum: got %h want 0", rsp_sum);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single(input string nm, input int i,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic sub, input logic [63:0] want);
        rsp_ready = '1;
        set_op(i, a, b, sub);
        req_valid = N'(1) << i;
        #1;
        checks++;
        if (req_ready !== N'(1) << i) begin
            errors++;
            $display("FAIL %s_grant: got %b want %b", nm, req_ready, N'(1) << i);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got rv=%b busy=%b want rv=0000 busy=1",
                     nm, rsp_valid, busy);
        end
        tick();
        #1;
        checks++;
        if (rsp_valid !== N'(1) << i) begin
            errors++;
            $display("FAIL %s_rsp_valid: got %b want %b", nm, rsp_valid, N'(1) << i);
        end
        checks++;
        if (rsp_sum !== want) begin
            errors++;
            $display("FAIL %s_sum: got %h want %h", nm, rsp_sum, want);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [N-1:0] want_rr, want_rv;
        do_reset();
        rsp_ready = '1;
        req_valid = '1;
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < N; i++) set_op(i, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
            #1;
            expect_now();
            want_rr = (c < 5) ? N'(1) << (c % 4) : exp_rr;
            want_rv = (c >= 2) ? N'(1) << ((c - 2) % 4) : '0;
            checks++;
            if (req_ready !== want_rr) begin
                errors++;
                $display("FAIL stream_grant[%0d]: got %b want %b", c, req_ready, want_rr);
            end
            checks++;
            if (rsp_valid !== want_rv) begin
                errors++;
                $display("FAIL stream_rsp[%0d]: got %b want %b", c, rsp_valid, want_rv);
            end
            if (c >= 2) begin
                checks++;
                if (rsp_sum !== exp_sum) begin
                    errors++;
                    $display("FAIL stream_sum[%0d]: got %h want %h", c, rsp_sum, exp_sum);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 20; c++) begin
            req_valid = (c < 10) ? 4'b1010 : 4'b0000;
            rsp_ready = (c < 7) ? 4'b1101 : 4'b1111;
            set_op(1, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
            set_op(3, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
            #1;
            expect_now();
            checks++;
            if (req_ready !== exp_rr) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, req_ready, exp_rr);
            end
            checks++;
            if (rsp_valid !== exp_rv) begin
                errors++;
                $display("FAIL bp_rsp_valid[%0d]: got %b want %b", c, rsp_valid, exp_rv);
            end
            if (exp_rv != '0) begin
                checks++;
                if (rsp_sum !== exp_sum) begin
                    errors++;
                    $display("FAIL bp_sum[%0d]: got %h want %h", c, rsp_sum, exp_sum);
                end
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL bp_busy[%0d]: got %b want %b", c, busy, exp_busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = '0;
        req_valid = '1;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_flush: got rv=%b busy=%b rdy=%b want 0000 0 0000",
                     rsp_valid, busy, req_ready);
        end
        rst = 1'b0;
        rsp_ready = '1;
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL midreset_first_grant: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        int others;
        bit got3;
        do_reset();
        rsp_ready = '1;
        req_valid = '1;
        others = 0;
        got3 = 0;
        for (int c = 0; c < 8 && !got3; c++) begin
            #1;
            expect_now();
            checks++;
            if (req_ready !== exp_rr) begin
                errors++;
                $display("FAIL fair_grant[%0d]: got %b want %b", c, req_ready, exp_rr);
            end
            if (req_ready[3]) got3 = 1;
            else if (req_ready != '0) others++;
            tick();
        end
        checks++;
        if (!got3 || others > 3) begin
            errors++;
            $display("FAIL fairness: got granted=%0d after %0d others want granted=1 within 3",
                     got3, others);
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            req_valid = N'($urandom);
            rsp_ready = '0;
            for (int i = 0; i < N; i++) begin
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                req_a[64*i +: 64] = rand_fp();
                req_b[64*i +: 64] = ($urandom_range(0, 7) == 0) ? req_a[64*i +: 64] : rand_fp();
                req_sub[i] = 1'($urandom_range(0, 1));
            end
            #1;
            expect_now();
            checks++;
            if (req_ready !== exp_rr) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_rr);
            end
            checks++;
            if (rsp_valid !== exp_rv) begin
                errors++;
                $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", c, rsp_valid, exp_rv);
            end
            if (exp_rv != '0) begin
                checks++;
                if (rsp_sum !== exp_sum) begin
                    errors++;
                    $display("FAIL rnd_sum[%0d]: got %h want %h", c, rsp_sum, exp_sum);
                end
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, exp_busy);
            end
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 4; c++) tick();
        #1;
        checks++;
        if (busy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: got busy=%b pending=%0d want 0 0", busy, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single("add", 0, FP_ONE, FP_TWO, 1'b0, FP_THREE);
        test_single("sub", 2, FP_THREE, FP_ONE, 1'b1, FP_TWO);
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
